seq_counter_monitor: RTL and testbench

- Downstream consumer of the 0,2,4,7 ripple sequence counter; samples its 3-bit output in the system clock domain.
- Synchronises and de-glitches the sampled value, then checks each transition against the legal sequence 0→2→4→7→0.
- Reports lock status, error pulses, a saturating error count and a completed-wrap count to the test/status logic.

---
 rtl/seq_counter_monitor.sv | 139 +++++++++++++
 tb/tb_seq_counter_monitor.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_counter_monitor.sv
// seq_counter_monitor: synchronise, de-glitch and check the 0,2,4,7 ripple counter sequence
// Ports:
//   clk_i      system clock, rising edge
//   rst_i      synchronous active-high reset
//   clr_i      synchronous clear of err_cnt_o and wrap_cnt_o
//   q_i        asynchronous 3-bit counter value
//   val_o      last accepted value, val_vld_o pulses when it changes
//   locked_o   high while the sequence is locked
//   err_o      one-cycle pulse on a sequence error while locked
//   err_cnt_o  saturating error count
//   wrap_cnt_o wrapping count of locked 7->0 steps
//   hist_o     last 4 accepted values, newest in [2:0] (only with SEQ_MON_HIST_EN)
module seq_counter_monitor #(
    parameter int STABLE_CNT = 2,
    parameter int LOCK_STEPS = 4,
    parameter int ERR_CNT_W  = 8,
    parameter int WRAP_CNT_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    input  logic [2:0]            q_i,
    output logic [2:0]            val_o,
    output logic                  val_vld_o,
    output logic                  locked_o,
    output logic                  err_o,
    output logic [ERR_CNT_W-1:0]  err_cnt_o,
    output logic [WRAP_CNT_W-1:0] wrap_cnt_o
`ifdef SEQ_MON_HIST_EN
    ,
    output logic [11:0]           hist_o
`endif
);
    localparam int SW = $clog2(STABLE_CNT + 1);
    localparam int LW = $clog2(LOCK_STEPS + 1);

    typedef enum logic [1:0] {ACQ, LOCKED, ERR} state_t;

    state_t          state, state_nxt;
    logic [2:0]      sync1, sync2, cand;
    logic [SW-1:0]   stab, stab_nxt;
    logic [LW-1:0]   step_cnt, step_cnt_nxt, step_inc;
    logic            step, legal, err_nxt, wrap_inc;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= q_i;
            sync2 <= sync1;
        end
    end

    // The candidate always follows the synchronised sample; the counter
    // restarts whenever the sample moves and saturates at STABLE_CNT.
    always_comb begin
        stab_nxt = (sync2 != cand) ? SW'(1) : (stab == SW'(STABLE_CNT)) ? stab : stab + 1'b1;
        step     = (stab_nxt == SW'(STABLE_CNT)) && (sync2 != val_o);
        legal    = (val_o == 3'd0 && sync2 == 3'd2) || (val_o == 3'd2 && sync2 == 3'd4) ||
                   (val_o == 3'd4 && sync2 == 3'd7) || (val_o == 3'd7 && sync2 == 3'd0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ACQ;
            step_cnt <= '0;
        end else begin
            state    <= state_nxt;
            step_cnt <= step_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        step_cnt_nxt = step_cnt;
        step_inc     = step_cnt + 1'b1;
        case (state)
            ACQ: if (step) begin
                step_cnt_nxt = legal ? step_inc : '0;
                if (legal && step_inc == LW'(LOCK_STEPS)) begin
                    state_nxt    = LOCKED;
                    step_cnt_nxt = '0;
                end
            end
            LOCKED: if (step && !legal) begin
                state_nxt    = ERR;
                step_cnt_nxt = '0;
            end
            default: begin
                state_nxt    = ACQ;
                step_cnt_nxt = '0;
            end
        endcase
    end

    always_comb begin
        err_nxt  = (state == LOCKED) && step && !legal;
        wrap_inc = (state == LOCKED) && step && legal && (val_o == 3'd7);
    end

    // locked_o follows the next state so it moves together with the step pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cand       <= '0;
            stab       <= '0;
            val_o      <= '0;
            val_vld_o  <= 1'b0;
            locked_o   <= 1'b0;
            err_o      <= 1'b0;
            err_cnt_o  <= '0;
            wrap_cnt_o <= '0;
        end else begin
            cand       <= sync2;
            stab       <= stab_nxt;
            val_o      <= step ? sync2 : val_o;
            val_vld_o  <= step;
            locked_o   <= (state_nxt == LOCKED);
            err_o      <= err_nxt;
            err_cnt_o  <= clr_i ? '0 : (err_nxt && !(&err_cnt_o)) ? err_cnt_o + 1'b1 : err_cnt_o;
            wrap_cnt_o <= clr_i ? '0 : wrap_cnt_o + WRAP_CNT_W'(wrap_inc);
        end
    end

`ifdef SEQ_MON_HIST_EN
    logic frozen;

    // The erroring step still shifts in, so the offending value is captured before freezing.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hist_o <= '0;
            frozen <= 1'b0;
        end else begin
            hist_o <= (step && !frozen) ? {hist_o[8:0], sync2} : hist_o;
            frozen <= clr_i ? 1'b0 : (frozen | err_nxt);
        end
    end
`endif
endmodule

// File: tb/tb_seq_counter_monitor.sv
// tb_seq_counter_monitor: table, hand-written and random checks against a behavioural model
module tb_seq_counter_monitor;
    localparam int STABLE = 2;
    localparam int LOCKN  = 4;
    localparam int EW     = 2;
    localparam int WW     = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic [2:0]    q = 3'd7;
    logic [2:0]    val;
    logic          vld, locked, err;
    logic [EW-1:0] err_cnt;
    logic [WW-1:0] wrap_cnt;
`ifdef SEQ_MON_HIST_EN
    logic [11:0]   hist;
`endif

    always #5 clk = ~clk;

    seq_counter_monitor #(.STABLE_CNT(STABLE), .LOCK_STEPS(LOCKN), .ERR_CNT_W(EW), .WRAP_CNT_W(WW)) dut (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .q_i(q),
        .val_o(val), .val_vld_o(vld), .locked_o(locked), .err_o(err),
        .err_cnt_o(err_cnt), .wrap_cnt_o(wrap_cnt)
`ifdef SEQ_MON_HIST_EN
        , .hist_o(hist)
`endif
    );

    int total = 0, bad = 0, n_err = 0, n_vld = 0;

    function automatic int nxt(int v);
        return v == 0 ? 2 : v == 2 ? 4 : v == 4 ? 7 : v == 7 ? 0 : -1;
    endfunction

    // Behavioural model: q delayed two samples, run-length filter, legal successor table.
    int pipe[$] = '{0, 0};
    int m_hist[$] = '{0, 0, 0, 0};
    int run_val = 0, run_len = 0, m_val = 0, m_vld = 0, m_locked = 0, m_err = 0;
    int m_errc = 0, m_wrap = 0, legal_run = 0, in_err = 0, frozen = 0;

    always @(posedge clk) begin : model
        int samp, was_err, step, legal, e_inc, w_inc;
        if (rst) begin
            pipe = '{0, 0}; m_hist = '{0, 0, 0, 0};
            run_val = 0; run_len = 0; m_val = 0; m_vld = 0; m_locked = 0; m_err = 0;
            m_errc = 0; m_wrap = 0; legal_run = 0; in_err = 0; frozen = 0;
        end else begin
            samp = pipe.pop_front();
            pipe.push_back(int'(q));
            if (samp != run_val) begin
                run_val = samp;
                run_len = 1;
            end else if (run_len < STABLE) run_len++;
            step = (run_len == STABLE && run_val != m_val) ? 1 : 0;
            legal = (step != 0 && nxt(m_val) == run_val) ? 1 : 0;
            was_err = in_err; in_err = 0; e_inc = 0; w_inc = 0;
            if (step != 0) begin
                if (m_locked != 0) begin
                    if (legal == 0) begin
                        e_inc = 1; m_locked = 0; in_err = 1; legal_run = 0;
                    end else if (m_val == 7) w_inc = 1;
                end else if (was_err == 0) begin
                    legal_run = (legal != 0) ? legal_run + 1 : 0;
                    if (legal_run == LOCKN) begin
                        m_locked = 1; legal_run = 0;
                    end
                end
                if (frozen == 0) begin
                    void'(m_hist.pop_front());
                    m_hist.push_back(run_val);
                end
                m_val = run_val;
            end
            m_vld = step; m_err = e_inc;
            m_errc = clr ? 0 : (e_inc != 0 && m_errc < (1 << EW) - 1) ? m_errc + 1 : m_errc;
            m_wrap = clr ? 0 : (m_wrap + w_inc) % (1 << WW);
            frozen = clr ? 0 : ((frozen != 0 || e_inc != 0) ? 1 : 0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("val", 32'(val), m_val);
            chk("vld", 32'(vld), m_vld);
            chk("locked", 32'(locked), m_locked);
            chk("err", 32'(err), m_err);
            chk("err_cnt", 32'(err_cnt), m_errc);
            chk("wrap_cnt", 32'(wrap_cnt), m_wrap);
`ifdef SEQ_MON_HIST_EN
            chk("hist", 32'(hist), {m_hist[0][2:0], m_hist[1][2:0], m_hist[2][2:0], m_hist[3][2:0]});
`endif
            if (err === 1'b1) n_err++;
            if (vld === 1'b1) n_vld++;
        end
    endtask

    task automatic hold(input int v, input int n);
        q = 3'(v);
        tick(n);
    endtask

    typedef struct {
        int q; int n; int val; int locked; int errc; int wrap;
    } vec_t;
    vec_t tbl[11];

    initial begin
        int cur, x, r;
        tbl[0]  = '{7, 4, 7, 0, 0, 0};
        tbl[1]  = '{0, 8, 0, 0, 0, 0};
        tbl[2]  = '{2, 8, 2, 0, 0, 0};
        tbl[3]  = '{4, 8, 4, 0, 0, 0};
        tbl[4]  = '{7, 8, 7, 1, 0, 0};
        tbl[5]  = '{0, 8, 0, 1, 0, 1};
        tbl[6]  = '{2, 8, 2, 1, 0, 1};
        tbl[7]  = '{4, 8, 4, 1, 0, 1};
        tbl[8]  = '{7, 8, 7, 1, 0, 1};
        tbl[9]  = '{0, 8, 0, 1, 0, 2};
        tbl[10] = '{2, 8, 2, 1, 0, 2};

        tick(3);
        chk("rst_val", 32'(val), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_err_cnt", 32'(err_cnt), 0);
        chk("rst_wrap_cnt", 32'(wrap_cnt), 0);
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick(1);
            chk("latency_vld", 32'(vld), (i == 4) ? 1 : 0);
        end

        for (int i = 0; i < 11; i++) begin
            hold(tbl[i].q, tbl[i].n);
            chk("tbl_val", 32'(val), tbl[i].val);
            chk("tbl_locked", 32'(locked), tbl[i].locked);
            chk("tbl_err_cnt", 32'(err_cnt), tbl[i].errc);
            chk("tbl_wrap_cnt", 32'(wrap_cnt), tbl[i].wrap);
        end

        n_err = 0;
        hold(7, 8);
        chk("seqerr_pulses", n_err, 1);
        chk("seqerr_err_cnt", 32'(err_cnt), 1);
        chk("seqerr_locked", 32'(locked), 0);
`ifdef SEQ_MON_HIST_EN
        chk("seqerr_hist", 32'(hist), 12'hE17);
`endif
        hold(0, 8); hold(2, 8); hold(4, 8);
        chk("relock_early", 32'(locked), 0);
        hold(7, 8);
        chk("relock", 32'(locked), 1);
        hold(0, 8);
        chk("relock_wrap", 32'(wrap_cnt), 3);
        hold(2, 8);

        n_err = 0; n_vld = 0;
        hold(6, 1);
        hold(4, 8);
        chk("glitch_vld", n_vld, 1);
        chk("glitch_err", n_err, 0);
        chk("glitch_val", 32'(val), 4);
        chk("glitch_locked", 32'(locked), 1);

        cur = 4;
        for (int e = 0; e < 5; e++) begin
            x = nxt(nxt(cur));
            hold(x, 8);
            for (int s = 0; s < 4; s++) begin
                x = nxt(x);
                hold(x, 8);
            end
            chk("sat_relock", 32'(locked), 1);
            cur = x;
        end
        chk("sat_err_cnt", 32'(err_cnt), 3);

        n_err = 0;
        clr = 1'b1;
        hold(nxt(nxt(cur)), 8);
        clr = 1'b0;
        chk("clr_err_pulse", n_err, 1);
        chk("clr_err_cnt", 32'(err_cnt), 0);
        chk("clr_wrap_cnt", 32'(wrap_cnt), 0);
        chk("clr_locked", 32'(locked), 0);

        cur = nxt(nxt(cur));
        for (int s = 0; s < 4; s++) begin
            cur = nxt(cur);
            hold(cur, 8);
        end
        chk("mid_locked", 32'(locked), 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("mid_rst_locked", 32'(locked), 0);
        chk("mid_rst_val", 32'(val), 0);
        chk("mid_rst_wrap", 32'(wrap_cnt), 0);
`ifdef SEQ_MON_HIST_EN
        chk("mid_rst_hist", 32'(hist), 0);
`endif

        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            clr = ($urandom_range(0, 19) == 0);
            rst = (r < 2);
            if (r < 12) cur = int'($urandom_range(0, 7));
            else cur = (nxt(cur) < 0) ? 0 : nxt(cur);
            hold(cur, int'($urandom_range(1, 6)));
            rst = 1'b0;
            clr = 1'b0;
        end
        tick(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
